// File: rtl/sitcp_frame_pkg.sv
// Frame constants, state encodings, error-flag indices and header decode for
// the SiTCP event checker.
package sitcp_frame_pkg;

    localparam int unsigned HDR_BYTES = 10;
    localparam int unsigned HIT_BYTES = 5;
    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned ERR_W     = 5;

    localparam logic [1:0] HDR_TAG = 2'b10;
    localparam logic [1:0] HIT_TAG = 2'b00;
    localparam logic [1:0] FTR_TAG = 2'b11;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_HIT    = 2'd2;
    localparam logic [1:0] ST_FOOTER = 2'd3;

    localparam int unsigned ERR_HDR_FMT = 0;
    localparam int unsigned ERR_HIT_FMT = 1;
    localparam int unsigned ERR_FTR_MIS = 2;
    localparam int unsigned ERR_SEQ     = 3;
    localparam int unsigned ERR_LEN     = 4;

    typedef struct packed {
        logic [23:0] evn;
        logic [23:0] len;
    } hdr_fields_t;

    // Header byte 0 sits in the top byte; EventNumber={b3[0],b4,b5,b6[7:1]}, DataLength={b7,b8,b9}.
    function automatic hdr_fields_t hdr_extract(input logic [HDR_W-1:0] hdr);
        hdr_fields_t f;
        f.evn = hdr[48:25];
        f.len = hdr[23:0];
        return f;
    endfunction

endpackage

// File: rtl/sitcp_event_checker_if.sv
// FIFO read port between the dummy SiTCP FIFO (master) and the checker (slave).
//   SiTcpFifoEmpty  FIFO empty
//   SiTcpFifoValid  dout valid, one cycle after a read
//   SiTcpFifoRdData dout byte
//   SiTcpFifoRdEnb  read enable from the checker
interface sitcp_event_checker_if;
    logic       SiTcpFifoEmpty;
    logic       SiTcpFifoValid;
    logic [7:0] SiTcpFifoRdData;
    logic       SiTcpFifoRdEnb;

    modport master (output SiTcpFifoEmpty, SiTcpFifoValid, SiTcpFifoRdData,
                    input  SiTcpFifoRdEnb);
    modport slave  (input  SiTcpFifoEmpty, SiTcpFifoValid, SiTcpFifoRdData,
                    output SiTcpFifoRdEnb);
endinterface

// File: rtl/sitcp_seq_tracker.sv
// Event-number continuity tracker.
//   fin_i       completed (non-aborted) event this cycle
//   evn_i       its EventNumber
//   other_err_i event carries a non-SEQ error (LastEventNumber is then kept)
//   seq_err_c   combinational SEQ verdict for the completing event
//   last_evn_o  EventNumber of the last accepted event
module sitcp_seq_tracker (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        fin_i,
    input  logic [23:0] evn_i,
    input  logic        other_err_i,
    output logic        seq_err_c,
    output logic [23:0] last_evn_o
);
    logic        first_q, first_d;
    logic [23:0] last_q, last_d;

    // Increment wraps naturally in 24 bits, so FFFFFF -> 0 is continuous.
    always_comb begin
        first_d   = first_q;
        last_d    = last_q;
        seq_err_c = fin_i & ~first_q & (evn_i != last_q + 24'd1);
        if (fin_i) begin
            first_d = 1'b0;
            if (!other_err_i) last_d = evn_i;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            first_q <= 1'b1;
            last_q  <= '0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign last_evn_o = last_q;
endmodule

// File: rtl/sitcp_event_checker.sv
// SiTCP event-stream checker: drains the FIFO, parses header/hits/footer,
// checks framing, header/footer agreement and event-number continuity.
// Optional idle timeout mid-event enabled by `define SITCP_CHK_TIMEOUT_EN.
//   Clk, Rst        clock, synchronous active-high reset
//   Enable          allow FIFO reads
//   ClearErr        clear ErrFlags and ErrorCount (a new error wins)
//   fifo            FIFO read port (slave side)
//   EventCount      good events (wraps)
//   ErrorCount      errored events (saturates)
//   LastEventNumber last accepted EventNumber
//   ErrFlags        sticky error flags
//   ErrPulse        one pulse per errored event
//   InEvent         parser is inside an event
module sitcp_event_checker
    import sitcp_frame_pkg::*;
#(
    parameter logic [23:0] MAX_HITS = 24'd4095
`ifdef SITCP_CHK_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic                 ClearErr,
    sitcp_event_checker_if.slave fifo,
    output logic [23:0]          EventCount,
    output logic [15:0]          ErrorCount,
    output logic [23:0]          LastEventNumber,
    output logic [ERR_W-1:0]     ErrFlags,
    output logic                 ErrPulse,
    output logic                 InEvent
);
    logic [1:0]       state_q, state_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      hit_cnt_q, hit_cnt_d, hit_next_c;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [23:0]      evn_q, evn_d, len_q, len_d;
    logic             mism_q, mism_d;
    logic             done_c, abort_c;
    logic [ERR_W-1:0] err_c;
    hdr_fields_t      hdr_f;
    logic [7:0]       din;

    logic             fin_q, fin_full_q;
    logic [ERR_W-1:0] fin_err_q, evt_err_c, flags_q, flags_d;
    logic [23:0]      fin_evn_q, evt_cnt_q;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             bad_c, seq_err_c, pulse_q, in_event_q, rd_enb_q;

`ifdef SITCP_CHK_TIMEOUT_EN
    logic [15:0]      idle_q, idle_d;
`endif

    assign din = fifo.SiTcpFifoRdData;

    // Byte parser: the header is shifted in MSB-first, then rotated during the
    // footer so the byte to compare against is always the top byte.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        hit_cnt_d  = hit_cnt_q;
        hdr_d      = hdr_q;
        evn_d      = evn_q;
        len_d      = len_q;
        mism_d     = mism_q;
        done_c     = 1'b0;
        abort_c    = 1'b0;
        err_c      = '0;
        hit_next_c = hit_cnt_q + 24'd1;
        hdr_f      = hdr_extract({hdr_q[HDR_W-9:0], din});
`ifdef SITCP_CHK_TIMEOUT_EN
        idle_d     = '0;
`endif
        if (fifo.SiTcpFifoValid) begin
            case (state_q)
                ST_HUNT: begin
                    if (din[7:6] == HDR_TAG) begin
                        hdr_d      = {(HDR_W-8)'(0), din};
                        byte_idx_d = 4'd1;
                        state_d    = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    hdr_d      = {hdr_q[HDR_W-9:0], din};
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (byte_idx_q == 4'(HDR_BYTES - 1)) begin
                        evn_d      = hdr_f.evn;
                        len_d      = hdr_f.len;
                        byte_idx_d = '0;
                        hit_cnt_d  = '0;
                        mism_d     = 1'b0;
                        if (hdr_f.len == 24'd0) begin
                            state_d = ST_FOOTER;
                        end else if (hdr_f.len > MAX_HITS) begin
                            abort_c        = 1'b1;
                            err_c[ERR_LEN] = 1'b1;
                            state_d        = ST_HUNT;
                        end else begin
                            state_d = ST_HIT;
                        end
                    end
                end
                ST_HIT: begin
                    if (byte_idx_q == 4'd0 && din[7:6] != HIT_TAG) begin
                        abort_c            = 1'b1;
                        err_c[ERR_HIT_FMT] = 1'b1;
                        state_d            = ST_HUNT;
                        byte_idx_d         = '0;
                    end else if (byte_idx_q == 4'(HIT_BYTES - 1)) begin
                        byte_idx_d = '0;
                        hit_cnt_d  = hit_next_c;
                        if (hit_next_c == len_q) state_d = ST_FOOTER;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                default: begin
                    hdr_d      = {hdr_q[HDR_W-9:0], hdr_q[HDR_W-1 -: 8]};
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (byte_idx_q == 4'd0) begin
                        if (din[7:6] != FTR_TAG) begin
                            abort_c            = 1'b1;
                            err_c[ERR_HDR_FMT] = 1'b1;
                            state_d            = ST_HUNT;
                            byte_idx_d         = '0;
                        end else if (din[5:0] != hdr_q[HDR_W-3 -: 6]) begin
                            mism_d = 1'b1;
                        end
                    end else if (din != hdr_q[HDR_W-1 -: 8]) begin
                        mism_d = 1'b1;
                    end
                    if (byte_idx_q == 4'(HDR_BYTES - 1)) begin
                        done_c             = 1'b1;
                        err_c[ERR_FTR_MIS] = mism_d;
                        state_d            = ST_HUNT;
                        byte_idx_d         = '0;
                    end
                end
            endcase
        end
`ifdef SITCP_CHK_TIMEOUT_EN
        else if (state_q != ST_HUNT) begin
            idle_d = idle_q + 16'd1;
            if (idle_d == TIMEOUT_CYCLES) begin
                abort_c        = 1'b1;
                err_c[ERR_LEN] = 1'b1;
                state_d        = ST_HUNT;
                byte_idx_d     = '0;
                idle_d         = '0;
            end
        end
`endif
    end

    sitcp_seq_tracker u_seq (
        .Clk        (Clk),
        .Rst        (Rst),
        .fin_i      (fin_full_q),
        .evn_i      (fin_evn_q),
        .other_err_i(|fin_err_q),
        .seq_err_c  (seq_err_c),
        .last_evn_o (LastEventNumber)
    );

    // Event completion: merge parse errors with the sequence verdict.
    always_comb begin
        evt_err_c          = fin_err_q;
        evt_err_c[ERR_SEQ] = fin_err_q[ERR_SEQ] | seq_err_c;
        bad_c              = fin_q & (|evt_err_c);
        flags_d            = (ClearErr ? '0 : flags_q) | (fin_q ? evt_err_c : '0);
        err_cnt_d          = err_cnt_q;
        if (ClearErr)                        err_cnt_d = bad_c ? 16'd1 : 16'd0;
        else if (bad_c && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_HUNT;
            byte_idx_q <= '0;
            hit_cnt_q  <= '0;
            hdr_q      <= '0;
            evn_q      <= '0;
            len_q      <= '0;
            mism_q     <= 1'b0;
            fin_q      <= 1'b0;
            fin_full_q <= 1'b0;
            fin_err_q  <= '0;
            fin_evn_q  <= '0;
            evt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            flags_q    <= '0;
            pulse_q    <= 1'b0;
            in_event_q <= 1'b0;
            rd_enb_q   <= 1'b0;
`ifdef SITCP_CHK_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            hit_cnt_q  <= hit_cnt_d;
            hdr_q      <= hdr_d;
            evn_q      <= evn_d;
            len_q      <= len_d;
            mism_q     <= mism_d;
            fin_q      <= done_c | abort_c;
            fin_full_q <= done_c;
            fin_err_q  <= err_c;
            fin_evn_q  <= evn_q;
            if (fin_q && !bad_c) evt_cnt_q <= evt_cnt_q + 24'd1;
            err_cnt_q  <= err_cnt_d;
            flags_q    <= flags_d;
            pulse_q    <= bad_c;
            in_event_q <= (state_d != ST_HUNT);
            rd_enb_q   <= Enable & ~fifo.SiTcpFifoEmpty;
`ifdef SITCP_CHK_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign fifo.SiTcpFifoRdEnb = rd_enb_q;
    assign EventCount          = evt_cnt_q;
    assign ErrorCount          = err_cnt_q;
    assign ErrFlags            = flags_q;
    assign ErrPulse            = pulse_q;
    assign InEvent             = in_event_q;
endmodule

// File: tb/tb_sitcp_event_checker.sv
// Directed bench for sitcp_event_checker with a behavioural FIFO model.
module tb_sitcp_event_checker;
    logic        clk = 1'b0;
    logic        Rst, Enable, ClearErr;
    logic [23:0] EventCount, LastEventNumber;
    logic [15:0] ErrorCount;
    logic [4:0]  ErrFlags;
    logic        ErrPulse, InEvent;
    logic        stall = 1'b0;
    logic [7:0]  fq[$];
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    int          p0;

    sitcp_event_checker_if fifo ();

`ifdef SITCP_CHK_TIMEOUT_EN
    sitcp_event_checker #(.TIMEOUT_CYCLES(16'd16)) dut (
`else
    sitcp_event_checker dut (
`endif
        .Clk(clk), .Rst(Rst), .Enable(Enable), .ClearErr(ClearErr), .fifo(fifo),
        .EventCount(EventCount), .ErrorCount(ErrorCount),
        .LastEventNumber(LastEventNumber), .ErrFlags(ErrFlags),
        .ErrPulse(ErrPulse), .InEvent(InEvent));

    always #5 clk = ~clk;

    // FIFO model: standard read mode, one-cycle read latency.
    initial begin
        fifo.SiTcpFifoEmpty  = 1'b1;
        fifo.SiTcpFifoValid  = 1'b0;
        fifo.SiTcpFifoRdData = 8'h00;
    end
    always @(posedge clk) begin
        int n;
        n = fq.size();
        if (fifo.SiTcpFifoRdEnb && n > 0) begin
            fifo.SiTcpFifoValid  <= 1'b1;
            fifo.SiTcpFifoRdData <= fq.pop_front();
            n--;
        end else begin
            fifo.SiTcpFifoValid <= 1'b0;
        end
        fifo.SiTcpFifoEmpty <= (n == 0) || stall;
    end

    always @(negedge clk) if (ErrPulse === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_event(input logic [23:0] evn, input logic [23:0] len,
                              input int bad_hit, input int ftr_bad, input bit hdr_only);
        logic [7:0] h [10];
        logic [7:0] f [10];
        h[0] = 8'hA5; h[1] = 8'h12; h[2] = 8'h34; h[3] = {7'h2A, evn[23]};
        h[4] = evn[22:15]; h[5] = evn[14:7]; h[6] = {evn[6:0], 1'b1};
        h[7] = len[23:16]; h[8] = len[15:8]; h[9] = len[7:0];
        for (int k = 0; k < 10; k++) fq.push_back(h[k]);
        if (hdr_only) return;
        for (int i = 0; i < int'(len); i++) begin
            if (i == bad_hit) begin
                fq.push_back(8'h40);
                return;
            end
            fq.push_back({2'b00, i[5:0]});
            for (int k = 1; k < 5; k++) fq.push_back(8'(i * 7 + k));
        end
        for (int k = 0; k < 10; k++) f[k] = h[k];
        f[0] = {2'b11, h[0][5:0]};
        if (ftr_bad >= 0) f[ftr_bad] = f[ftr_bad] ^ 8'h01;
        for (int k = 0; k < 10; k++) fq.push_back(f[k]);
    endtask

    task automatic wait_done(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < 40000) begin
            @(negedge clk);
            n++;
            if (fq.size() == 0 && fifo.SiTcpFifoValid == 1'b0 && InEvent == 1'b0) quiet++;
            else quiet = 0;
        end
        check({tag, "_drained"}, 32'(quiet >= 6), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1'b1;
        repeat (2) @(negedge clk);
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Enable = 1'b0; ClearErr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_evcnt", 32'(EventCount), 32'd0);
        check("rst_errcnt", 32'(ErrorCount), 32'd0);
        check("rst_last", 32'(LastEventNumber), 32'd0);
        check("rst_flags", 32'(ErrFlags), 32'd0);
        check("rst_inevent", 32'(InEvent), 32'd0);
        check("rst_rdenb", 32'(fifo.SiTcpFifoRdEnb), 32'd0);
        Rst = 1'b0; Enable = 1'b1;

        // three long back-to-back events
        for (int e = 0; e < 3; e++) push_event(24'(e), 24'd1000, -1, -1, 1'b0);
        wait_done("b2b");
        check("b2b_evcnt", 32'(EventCount), 32'd3);
        check("b2b_flags", 32'(ErrFlags), 32'd0);
        check("b2b_last", 32'(LastEventNumber), 32'd2);
        check("b2b_errcnt", 32'(ErrorCount), 32'd0);

        // event-number wrap
        do_reset();
        push_event(24'hFFFFFE, 24'd3, -1, -1, 1'b0);
        push_event(24'hFFFFFF, 24'd3, -1, -1, 1'b0);
        push_event(24'h000000, 24'd3, -1, -1, 1'b0);
        wait_done("wrap");
        check("wrap_evcnt", 32'(EventCount), 32'd3);
        check("wrap_flags", 32'(ErrFlags), 32'd0);
        check("wrap_last", 32'(LastEventNumber), 32'd0);

        // sequence gap resyncs LastEventNumber
        do_reset();
        p0 = pulses;
        push_event(24'd5, 24'd2, -1, -1, 1'b0);
        push_event(24'd7, 24'd2, -1, -1, 1'b0);
        wait_done("seq");
        check("seq_flags", 32'(ErrFlags), 32'h08);
        check("seq_errcnt", 32'(ErrorCount), 32'd1);
        check("seq_pulses", 32'(pulses - p0), 32'd1);
        check("seq_last", 32'(LastEventNumber), 32'd7);
        check("seq_evcnt", 32'(EventCount), 32'd1);

        // footer mismatch, then a good event, then ClearErr
        do_reset();
        push_event(24'd0, 24'd4, -1, 6, 1'b0);
        push_event(24'd1, 24'd4, -1, -1, 1'b0);
        wait_done("ftr");
        check("ftr_flags", 32'(ErrFlags), 32'h04);
        check("ftr_errcnt", 32'(ErrorCount), 32'd1);
        check("ftr_evcnt", 32'(EventCount), 32'd1);
        check("ftr_last", 32'(LastEventNumber), 32'd1);
        ClearErr = 1'b1;
        @(negedge clk);
        ClearErr = 1'b0;
        check("clr_flags", 32'(ErrFlags), 32'd0);
        check("clr_errcnt", 32'(ErrorCount), 32'd0);
        check("clr_evcnt", 32'(EventCount), 32'd1);

        // bad hit tag at hit 17, junk, then a clean event
        do_reset();
        p0 = pulses;
        push_event(24'd0, 24'd20, 17, -1, 1'b0);
        fq.push_back(8'h00); fq.push_back(8'h55); fq.push_back(8'hFF);
        push_event(24'd1, 24'd2, -1, -1, 1'b0);
        wait_done("hit");
        check("hit_flags", 32'(ErrFlags), 32'h02);
        check("hit_errcnt", 32'(ErrorCount), 32'd1);
        check("hit_evcnt", 32'(EventCount), 32'd1);
        check("hit_last", 32'(LastEventNumber), 32'd1);
        check("hit_pulses", 32'(pulses - p0), 32'd1);

        // DataLength above MAX_HITS, then a zero-length event
        do_reset();
        push_event(24'd3, 24'd4096, -1, -1, 1'b1);
        push_event(24'd3, 24'd0, -1, -1, 1'b0);
        wait_done("len");
        check("len_flags", 32'(ErrFlags), 32'h10);
        check("len_errcnt", 32'(ErrorCount), 32'd1);
        check("len_evcnt", 32'(EventCount), 32'd1);
        check("len_last", 32'(LastEventNumber), 32'd3);

        // Enable dropped mid-event holds the parse
        push_event(24'd4, 24'd6, -1, -1, 1'b0);
        repeat (20) @(negedge clk);
        Enable = 1'b0;
        repeat (4) @(negedge clk);
        check("en_rdenb", 32'(fifo.SiTcpFifoRdEnb), 32'd0);
        repeat (10) @(negedge clk);
        check("en_inevent", 32'(InEvent), 32'd1);
        check("en_hold_evcnt", 32'(EventCount), 32'd1);
        Enable = 1'b1;
        wait_done("en");
        check("en_evcnt", 32'(EventCount), 32'd2);
        check("en_last", 32'(LastEventNumber), 32'd4);
        check("en_flags", 32'(ErrFlags), 32'h10);

        // Rst mid-header clears everything next cycle
        push_event(24'd5, 24'd1, -1, -1, 1'b0);
        repeat (6) @(negedge clk);
        check("rmid_inevent", 32'(InEvent), 32'd1);
        Rst = 1'b1;
        @(negedge clk);
        check("rmid_evcnt", 32'(EventCount), 32'd0);
        check("rmid_errcnt", 32'(ErrorCount), 32'd0);
        check("rmid_last", 32'(LastEventNumber), 32'd0);
        check("rmid_flags", 32'(ErrFlags), 32'd0);
        check("rmid_inevent0", 32'(InEvent), 32'd0);
        check("rmid_rdenb", 32'(fifo.SiTcpFifoRdEnb), 32'd0);
        fq.delete();
        Rst = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SITCP_CHK_TIMEOUT_EN
        // FIFO stall mid-hit trips the idle timeout
        do_reset();
        push_event(24'd0, 24'd8, -1, -1, 1'b0);
        repeat (16) @(negedge clk);
        stall = 1'b1;
        repeat (22) @(negedge clk);
        check("to_flags", 32'(ErrFlags), 32'h10);
        check("to_inevent", 32'(InEvent), 32'd0);
        check("to_errcnt", 32'(ErrorCount), 32'd1);
        fq.delete();
        stall = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sitcp_event_checker.md
Name: sitcp_event_checker

Overview:
- Sits downstream of the dummy SiTCP FIFO generator, in the gt_txusrclk domain.
- Drains the 8-bit FIFO read port and parses the byte stream as events: 10-byte header, DataLength × 5-byte hits, 10-byte footer.
- Checks framing, header/footer agreement and event-number continuity.
- Exposes counters and sticky error flags for ILA and slow control.

Parameters:
- HDR_BYTES, 10, header and footer length in bytes.
- HIT_BYTES, 5, bytes per hit word.
- MAX_HITS, 24'd4095, DataLength above this raises ERR_LEN.
- TIMEOUT_CYCLES, 16'd1024, idle cycles mid-event before abort (optional feature only).

Ports:
- Clk  in  1  gt_txusrclk_in; the only clock.
- Rst  in  1  synchronous, active-high reset.
- Enable  in  1  allows FIFO reads.
- ClearErr  in  1  one-cycle pulse; clears ErrFlags and ErrorCount.
- SiTcpFifoEmpty  in  1  FIFO empty.
- SiTcpFifoValid  in  1  FIFO dout valid (standard read mode, 1-cycle latency).
- SiTcpFifoRdData  in  8  FIFO dout.
- SiTcpFifoRdEnb  out  1  FIFO read enable.
- EventCount  out  24  good events; wraps.
- ErrorCount  out  16  errored events; saturates at 16'hFFFF.
- LastEventNumber  out  24  EventNumber of the last good event.
- ErrFlags  out  5  sticky: [0] HDR_FMT, [1] HIT_FMT, [2] FTR_MISMATCH, [3] SEQ, [4] TIMEOUT/LEN.
- ErrPulse  out  1  one-cycle pulse per errored event.
- InEvent  out  1  high from header byte 0 accepted until footer byte 9 consumed.

Behaviour:
- Reset values: all outputs 0; state HUNT; first_event flag set.
- Read side:
  - SiTcpFifoRdEnb = Enable & ~SiTcpFifoEmpty & ~Rst, registered.
  - A byte is consumed only on a cycle with SiTcpFifoValid=1. Bytes are never consumed on RdEnb alone.
- States: HUNT, HEADER, HIT, FOOTER. Byte index counter byte_idx is 4 bits.
- HUNT:
  - Valid byte with [7:6]==2'b10: store as header byte 0, byte_idx=1, go to HEADER.
  - Any other byte: discard, no error.
- HEADER:
  - Store bytes 1..9 into an 80-bit header register.
  - After byte 9, decode:
    - EventNumber = {b3[0], b4, b5, b6[7:1]}.
    - DataLength = {b7, b8, b9}.
  - DataLength==0: go to FOOTER.
  - DataLength>MAX_HITS: raise ERR_LEN, go to HUNT.
  - Otherwise go to HIT with hit_cnt=0.
- HIT:
  - Byte 0 of each hit must have [7:6]==2'b00, else raise HIT_FMT and go to HUNT.
  - hit_cnt increments after byte 4.
  - When hit_cnt reaches DataLength, go to FOOTER.
- FOOTER:
  - Byte 0 [7:6] must equal 2'b11, else raise HDR_FMT (framing) and go to HUNT.
  - Footer bytes 0[5:0] and 1..9 must equal the corresponding header bits. A mismatch sets FTR_MISMATCH at footer end.
  - After byte 9, go to HUNT.
- Event completion (cycle after footer byte 9):
  - Sequence check: if first_event==0 and EventNumber != LastEventNumber+1 (mod 2^24; 24'hFFFFFF→0 is legal), set SEQ.
  - If no error: EventCount+1, LastEventNumber<=EventNumber.
  - Any error (including aborts): ErrorCount+1 (saturating) and a single ErrPulse for that event.
  - first_event cleared after any completed event. LastEventNumber still updates on a SEQ-only error, so the checker resyncs.
- Simultaneous events: ClearErr in the same cycle as a new error leaves the new error set (set wins).
- Enable deassert mid-event: reads stop, state is held, parsing resumes on re-enable.
- Rst mid-event: immediate return to HUNT; partial event is not counted.

Optional Feature:
- Macro: SITCP_CHK_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs while not in HUNT and no valid byte arrives.
  - It resets on every valid byte.
  - At TIMEOUT_CYCLES: set ErrFlags[4], count an errored event, go to HUNT.
- Undefined: no counter; ErrFlags[4] is driven only by ERR_LEN.

Decomposition:
- Package sitcp_frame_pkg:
  - HDR_BYTES, HIT_BYTES.
  - Fixed words HDR_TAG=2'b10, HIT_TAG=2'b00, FTR_TAG=2'b11.
  - State enum.
  - ErrFlags bit indices.
  - A header-field extract function (EventNumber, DataLength from 80-bit header).
- Sub-module sitcp_seq_tracker: owns first_event, LastEventNumber and the wrap-aware SEQ compare. Everything else stays flat.

Test Plan:
- Three back-to-back events, DataLength=1000, EventNumber 0,1,2 → EventCount=3, ErrFlags=0, LastEventNumber=2, ErrorCount=0.
- Events with EventNumber 24'hFFFFFE, 24'hFFFFFF, 0 → no SEQ error, EventCount=3.
- EventNumber 5 then 7 → ErrFlags[3]=1, ErrorCount=1, one ErrPulse, LastEventNumber=7.
- Footer byte 6 corrupted → FTR_MISMATCH set, ErrorCount=1; following good event counted; ClearErr returns ErrFlags to 0.
- Hit byte 0 = 8'h40 at hit 17 → HIT_FMT, return to HUNT; three junk bytes (8'h00, 8'h55, 8'hFF) then a valid header → next event parsed cleanly.
- With SITCP_CHK_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall FIFO 20 cycles mid-hit → ErrFlags[4]=1, InEvent=0; Rst asserted mid-header → all outputs 0 next cycle.
